// File: rtl/window_sum_count_if.sv
// window_sum_count_if
//  Bundles the sample-stream input, the result port and the two control
//  strobes of window_sum_count into one interface.
//  Signals:
//   clr        synchronous abort of the current window and any held result
//   in_valid   sample valid
//   in_data    8-bit unsigned sample
//   in_ready   stage can accept a sample
//   flush      close the current window early
//   out_valid  op1/op2 hold a completed window
//   out_ready  downstream has taken the result
//   op1        16-bit window sum (divider dividend)
//   op2        8-bit window sample count (divider divisor)
//  Modports:
//   master  environment view (drives samples/controls, consumes results)
//   slave   window_sum_count view
interface window_sum_count_if;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] op1;
  logic [7:0]  op2;

  modport master (
    output clr, in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, op1, op2
  );

  modport slave (
    input  clr, in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, op1, op2
  );
endinterface

// File: rtl/window_sum_count.sv
// window_sum_count
//  Accumulates a window of 8-bit samples into a 16-bit sum and an 8-bit
//  count, then presents (sum, count) as the operand pair of the downstream
//  16/8 saturating divider so it can form a windowed average.
//  A window closes when it reaches MAX_CNT samples, or early on flush
//  (only if it contains at least one sample). The closed result is held
//  stable on op1/op2 until out_ready; no samples are accepted meanwhile.
//  Parameters:
//   MAX_CNT  window length in samples, 1..255
//  Configuration macro:
//   ACCUM_ROUND_EN  when defined, op1 = sum + (count >> 1) at close so the
//                   divider's truncating quotient rounds half-up
//  Ports:
//   clk  clock, rising edge
//   rst  asynchronous reset, active-low
//   bus  window_sum_count_if.slave (sample stream, result port, clr/flush)
module window_sum_count #(
  parameter int MAX_CNT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  window_sum_count_if.slave     bus
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] sum;
  logic [7:0]  cnt;
  logic [15:0] sum_after;
  logic [7:0]  cnt_after;
  logic [15:0] op1_load;
  logic        accept;
  logic        close;

  // in_ready is a pure function of state, so accept can use it directly.
  assign accept    = bus.in_valid & bus.in_ready;
  assign sum_after = sum + (accept ? {8'd0, bus.in_data} : 16'd0);
  assign cnt_after = cnt + {7'd0, accept};

  // A flush only closes a non-empty window; clr suppresses any close.
  assign close = (state == ACC) && !bus.clr &&
                 ((cnt_after == 8'(MAX_CNT)) ||
                  (bus.flush && (cnt_after != 8'd0)));

`ifdef ACCUM_ROUND_EN
  assign op1_load = sum_after + {9'd0, cnt_after[7:1]};
`else
  assign op1_load = sum_after;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACC;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.clr) begin
      state_next = ACC;
    end else begin
      case (state)
        ACC:     if (close)         state_next = HOLD;
        HOLD:    if (bus.out_ready) state_next = ACC;
        default:                    state_next = ACC;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ACC:     bus.in_ready  = 1'b1;
      HOLD:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
  end

  // op1/op2 only move at a close edge so the divider sees stable operands
  // for the whole hold period; clr deliberately leaves them untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum     <= 16'd0;
      cnt     <= 8'd0;
      bus.op1 <= 16'd0;
      bus.op2 <= 8'd0;
    end else if (bus.clr) begin
      sum <= 16'd0;
      cnt <= 8'd0;
    end else if (close) begin
      bus.op1 <= op1_load;
      bus.op2 <= cnt_after;
      sum     <= 16'd0;
      cnt     <= 8'd0;
    end else if (accept) begin
      sum <= sum_after;
      cnt <= cnt_after;
    end
  end

endmodule

// File: tb/tb_window_sum_count.sv
// tb_window_sum_count
//  Directed bench for window_sum_count. Two instances share clk/rst:
//  one with a 4-sample window, one with the full 255-sample window.
//  Expected values are hand-computed constants; the rounded variants
//  apply when ACCUM_ROUND_EN is defined.
module tb_window_sum_count;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  window_sum_count_if b4 ();
  window_sum_count_if b255 ();

  window_sum_count #(.MAX_CNT(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  window_sum_count #(.MAX_CNT(255)) dut255 (
    .clk (clk),
    .rst (rst),
    .bus (b255.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ACCUM_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample #1 after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [7:0] data,
                                input logic fl, input logic rdy,
                                input logic cl);
    b4.in_valid  = valid;
    b4.in_data   = data;
    b4.flush     = fl;
    b4.out_ready = rdy;
    b4.clr       = cl;
  endtask

  initial begin
    rst = 1'b0;
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    b255.in_valid  = 1'b0;
    b255.in_data   = 8'd0;
    b255.flush     = 1'b0;
    b255.out_ready = 1'b0;
    b255.clr       = 1'b0;

    // Reset state
    #1;
    check_output("rst_out_valid", 32'(b4.out_valid), 32'd0);
    check_output("rst_op1", 32'(b4.op1), 32'd0);
    check_output("rst_op2", 32'(b4.op2), 32'd0);
    check_output("rst_in_ready", 32'(b4.in_ready), 32'd1);
    #21;
    rst = 1'b1;
    @(negedge clk);

    // 1: 10,20,30,40 back-to-back, out_ready=1
    apply_stimulus(1'b1, 8'd10, 1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b1, 8'd20, 1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b1, 8'd30, 1'b0, 1'b1, 1'b0);
    tick();
    check_output("t1_no_early_valid", 32'(b4.out_valid), 32'd0);
    apply_stimulus(1'b1, 8'd40, 1'b0, 1'b1, 1'b0);
    tick();
    check_output("t1_out_valid", 32'(b4.out_valid), 32'd1);
    check_output("t1_op1", 32'(b4.op1), ROUND ? 32'd102 : 32'd100);
    check_output("t1_op2", 32'(b4.op2), 32'd4);
    check_output("t1_in_ready_low", 32'(b4.in_ready), 32'd0);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    tick();
    check_output("t1_in_ready_back", 32'(b4.in_ready), 32'd1);
    check_output("t1_out_valid_fall", 32'(b4.out_valid), 32'd0);
    check_output("t1_op1_kept", 32'(b4.op1), ROUND ? 32'd102 : 32'd100);

    // 2: 7,8,9 then flush alone
    apply_stimulus(1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 8'd8, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("t2_out_valid", 32'(b4.out_valid), 32'd1);
    check_output("t2_op1", 32'(b4.op1), ROUND ? 32'd25 : 32'd24);
    check_output("t2_op2", 32'(b4.op2), 32'd3);
    // Flush in HOLD is ignored and not queued.
    apply_stimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    tick();
    check_output("t2_release", 32'(b4.out_valid), 32'd0);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_output("t2_flush_not_queued", 32'(b4.out_valid), 32'd0);

    // 3: flush on empty window, then sample+flush on the same edge
    apply_stimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("t3_empty_flush_valid", 32'(b4.out_valid), 32'd0);
    check_output("t3_empty_flush_ready", 32'(b4.in_ready), 32'd1);
    apply_stimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("t3_out_valid", 32'(b4.out_valid), 32'd1);
    check_output("t3_op1", 32'(b4.op1), 32'd5);
    check_output("t3_op2", 32'(b4.op2), 32'd1);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    tick();

    // 5: clr mid-window after 3 samples, then 4 samples of 1
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 8'd50, 1'b0, 1'b0, 1'b0);
      tick();
    end
    apply_stimulus(1'b1, 8'd99, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("t5_clr_no_valid", 32'(b4.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check_output("t5_out_valid", 32'(b4.out_valid), 32'd1);
    check_output("t5_op1", 32'(b4.op1), ROUND ? 32'd6 : 32'd4);
    check_output("t5_op2", 32'(b4.op2), 32'd4);
    apply_stimulus(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    tick();
    check_output("t5_hold", 32'(b4.out_valid), 32'd1);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("t5_clr_hold_drop", 32'(b4.out_valid), 32'd0);
    check_output("t5_clr_keeps_op1", 32'(b4.op1), ROUND ? 32'd6 : 32'd4);

    // 6: async reset mid-HOLD
    apply_stimulus(1'b1, 8'd60, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 8'd70, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("t6_hold_valid", 32'(b4.out_valid), 32'd1);
    check_output("t6_hold_op1", 32'(b4.op1), ROUND ? 32'd131 : 32'd130);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_output("t6_rst_valid", 32'(b4.out_valid), 32'd0);
    check_output("t6_rst_op1", 32'(b4.op1), 32'd0);
    check_output("t6_rst_op2", 32'(b4.op2), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check_output("t6_after_valid", 32'(b4.out_valid), 32'd1);
    check_output("t6_after_op1", 32'(b4.op1), ROUND ? 32'd10 : 32'd8);
    check_output("t6_after_op2", 32'(b4.op2), 32'd4);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    tick();

    // 4: 255-sample window of 255, then 10 cycles of backpressure
    b255.in_valid = 1'b1;
    b255.in_data  = 8'd255;
    for (int i = 0; i < 254; i++) tick();
    check_output("t4_no_early_valid", 32'(b255.out_valid), 32'd0);
    tick();
    check_output("t4_out_valid", 32'(b255.out_valid), 32'd1);
    check_output("t4_op1", 32'(b255.op1), ROUND ? 32'd65152 : 32'd65025);
    check_output("t4_op2", 32'(b255.op2), 32'd255);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("t4_bp_in_ready", 32'(b255.in_ready), 32'd0);
      check_output("t4_bp_op1", 32'(b255.op1), ROUND ? 32'd65152 : 32'd65025);
      check_output("t4_bp_op2", 32'(b255.op2), 32'd255);
    end
    b255.in_valid  = 1'b0;
    b255.out_ready = 1'b1;
    tick();
    check_output("t4_release", 32'(b255.out_valid), 32'd0);
    // Nothing leaked in during backpressure: a single sample flushes as count 1.
    b255.out_ready = 1'b0;
    b255.in_valid  = 1'b1;
    b255.in_data   = 8'd3;
    b255.flush     = 1'b1;
    tick();
    b255.in_valid = 1'b0;
    b255.flush    = 1'b0;
    check_output("t4_after_op1", 32'(b255.op1), 32'd3);
    check_output("t4_after_op2", 32'(b255.op2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
